wb_timer: RTL and testbench
===========================

Name: wb_timer

Overview:
- Wishbone B3 classic slave timer/interrupt source on the SoC intercon, alongside RAM, UART and SDRAM slaves.
- Provides a 64-bit prescaled up-counter, a 64-bit compare register, auto-reload and a level interrupt to the picorv32 core.
- Gives firmware a time base and periodic tick without polling the UART or spinning on cycle counters.

Parameters:
- PRESCALE_W, 16, width of the prescaler divisor register and counter.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- wb_adr_i  in  5  byte address; bits [4:2] select the register, bits [1:0] are ignored.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables for writes.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  acknowledge, registered.
- wb_err_o  out  1  tied 0.
- irq_o  out  1  interrupt, level: pending & IRQ_EN.

Behaviour:
- Register map (byte offsets):
  - 0x00 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN.
  - 0x04 PRESCALE: [PRESCALE_W-1:0].
  - 0x08 COUNT_LO.
  - 0x0C COUNT_HI.
  - 0x10 CMP_LO.
  - 0x14 CMP_HI.
  - 0x18 STATUS: [0] PENDING, write-1-to-clear.
  - 0x1C reserved: reads 0, writes ignored.
  - Unused register bits read 0.
- Reset values: CTRL 0, PRESCALE 0, prescaler counter 0, COUNT 0, CMP 64'hFFFF_FFFF_FFFF_FFFF, PENDING 0, HI shadow 0, wb_ack_o 0, wb_dat_o 0, irq_o 0. Reset asserted mid-operation returns all state to these values on the next edge and aborts any bus access (no ack).
- Bus handshake:
  - Access is accepted when wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - wb_ack_o rises on the next edge and stays high for exactly 1 cycle, so the minimum access is 2 cycles and back-to-back accesses cannot receive consecutive acks.
  - A write commits on the accepting edge, per byte lane according to wb_sel_i.
  - Read data is registered and valid while wb_ack_o is high.
  - wb_cyc_i dropped before ack: the pending ack still fires 1 cycle later; the master ignores it.
- Tick generation:
  - While EN=1, the prescaler counts 0..PRESCALE.
  - Tick is asserted in the cycle the prescaler equals PRESCALE; the prescaler then returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - EN=0 freezes both the prescaler and COUNT.
- Counting on tick:
  - If COUNT == CMP: set PENDING. If AUTO_RELOAD=1, COUNT <= 0 (period CMP+1 ticks); otherwise COUNT <= COUNT+1.
  - Otherwise COUNT <= COUNT+1.
  - Non-reload mode wraps 64'hFFFF_FFFF_FFFF_FFFF to 0.
- Coherent 64-bit read:
  - A read of COUNT_LO latches COUNT[63:32] into the HI shadow in the same edge.
  - A read of COUNT_HI returns the shadow, not the live value.
- Simultaneous events:
  - Bus write to COUNT_LO/HI in the same cycle as a tick: the write wins, and the prescaler is cleared to 0.
  - Write to CMP in the same cycle as a tick: the match is evaluated against the old CMP.
  - STATUS W1C in the same cycle as a new match: PENDING stays 1 (set wins).
  - Writing PRESCALE below the current prescaler value: the prescaler is cleared to 0.
- irq_o is combinational from registered PENDING and IRQ_EN (no added latency beyond the register update).

Optional Feature:
- Macro: WB_TIMER_ONESHOT_EN.
- With the macro defined:
  - CTRL[3] is ONESHOT (reset 0).
  - On a tick with a match and ONESHOT=1, EN is cleared in the same edge that sets PENDING.
  - COUNT then holds CMP+1, or 0 if AUTO_RELOAD=1.
- Without the macro: CTRL[3] reads 0 and writes to it are ignored; no one-shot logic is synthesized.

Test Plan:
- Reset, then read every offset -> CTRL 0, PRESCALE 0, COUNT_LO/HI 0, CMP_LO/HI 0xFFFFFFFF, STATUS 0, 0x1C 0; irq_o 0; every access acked exactly 1 cycle after stb.
- PRESCALE=3, CTRL=0x1; wait 40 cycles after the enabling ack; read COUNT_LO -> 10, with COUNT incrementing exactly every 4th cycle (checked by a per-cycle monitor).
- PRESCALE=0, CMP=5/0, CTRL=0x7 -> irq_o rises the cycle after COUNT==5 is ticked, COUNT becomes 0, period 6 cycles; write 0x1 to STATUS -> irq_o low next cycle, and high again 6 cycles later.
- COUNT_LO=0xFFFFFFFE, COUNT_HI=0, PRESCALE=0, EN=1; read COUNT_LO then COUNT_HI across the carry -> the pair is consistent (e.g. LO 0xFFFFFFFF with HI 0, or LO 0x00000001 with HI 1), never LO 0xFFFFFFFF with HI 1.
- Force a match on the same edge as a STATUS W1C write -> PENDING reads 1 and irq_o stays high.
- CMP_LO write 0xAABBCCDD with wb_sel_i=4'b0001 from reset -> reads 0xFFFFFFDD. With WB_TIMER_ONESHOT_EN, CTRL=0xF and CMP=2 -> after the match, CTRL reads 0xE and COUNT stays 0.

Source files
------------

// File: rtl/wb_timer_if.sv
// Wishbone B3 classic bus bundle between the intercon (master) and the timer slave.
interface wb_timer_if;
  logic [4:0]  adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] rdat;
  logic        ack;
  logic        err;

  modport master (output adr, wdat, sel, we, cyc, stb, input rdat, ack, err);
  modport slave  (input adr, wdat, sel, we, cyc, stb, output rdat, ack, err);
endinterface

// File: rtl/wb_timer.sv
// Wishbone slave timer: prescaled 64-bit up-counter, compare, auto-reload, level irq.
// Optional one-shot mode (CTRL[3]) is built only when WB_TIMER_ONESHOT_EN is defined.
module wb_timer #(
  parameter int PRESCALE_W = 16
) (
  input  logic      wb_clk_i,
  input  logic      wb_rst_i,
  wb_timer_if.slave wb,
  output logic      irq_o
);
`ifdef WB_TIMER_ONESHOT_EN
  localparam int CTRL_W = 4;
`else
  localparam int CTRL_W = 3;
`endif

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_PRESCALE = 3'd1,
    REG_COUNT_LO = 3'd2,
    REG_COUNT_HI = 3'd3,
    REG_CMP_LO   = 3'd4,
    REG_CMP_HI   = 3'd5,
    REG_STATUS   = 3'd6,
    REG_RSVD     = 3'd7
  } reg_e;

  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [63:0]           count_q, count_d;
  logic [63:0]           cmp_q, cmp_d;
  logic                  pending_q, pending_d;
  logic [31:0]           hi_shadow_q, hi_shadow_d;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;

  reg_e                  reg_sel;
  logic                  access, wr_en, rd_en, tick, match, unused_adr;
  logic [31:0]           rd_val, wr_old, wr_val;
  logic [PRESCALE_W-1:0] prescale_new;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

  assign reg_sel    = reg_e'(wb.adr[4:2]);
  assign unused_adr = ^wb.adr[1:0];
  assign access     = wb.cyc & wb.stb & ~ack_q;
  assign wr_en      = access & wb.we;
  assign rd_en      = access & ~wb.we;
  assign tick       = ctrl_q[0] & (psc_q == prescale_q);
  assign match      = tick & (count_q == cmp_q);

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_CTRL:     rd_val = 32'(ctrl_q);
      REG_PRESCALE: rd_val = 32'(prescale_q);
      REG_COUNT_LO: rd_val = count_q[31:0];
      REG_COUNT_HI: rd_val = hi_shadow_q;
      REG_CMP_LO:   rd_val = cmp_q[31:0];
      REG_CMP_HI:   rd_val = cmp_q[63:32];
      REG_STATUS:   rd_val = {31'd0, pending_q};
      default:      rd_val = '0;
    endcase
  end

  // Partial-lane writes to COUNT_HI merge into the live count, not the read shadow.
  assign wr_old       = (reg_sel == REG_COUNT_HI) ? count_q[63:32] : rd_val;
  assign wr_val       = byte_merge(wr_old, wb.wdat, wb.sel);
  assign prescale_new = wr_val[PRESCALE_W-1:0];

  always_comb begin
    ctrl_d      = ctrl_q;
    prescale_d  = prescale_q;
    psc_d       = psc_q;
    count_d     = count_q;
    cmp_d       = cmp_q;
    pending_d   = pending_q;
    hi_shadow_d = hi_shadow_q;
    ack_d       = access;
    dat_d       = dat_q;

    if (ctrl_q[0]) psc_d = tick ? '0 : psc_q + PRESCALE_W'(1);
    if (tick) count_d = (match && ctrl_q[1]) ? 64'd0 : count_q + 64'd1;

    if (rd_en) begin
      dat_d = rd_val;
      if (reg_sel == REG_COUNT_LO) hi_shadow_d = count_q[63:32];
    end

    if (wr_en) begin
      case (reg_sel)
        REG_CTRL:     ctrl_d = wr_val[CTRL_W-1:0];
        REG_PRESCALE: begin
          prescale_d = prescale_new;
          if (prescale_new < psc_q) psc_d = '0;
        end
        REG_COUNT_LO: begin
          count_d = {count_q[63:32], wr_val};
          psc_d   = '0;
        end
        REG_COUNT_HI: begin
          count_d = {wr_val, count_q[31:0]};
          psc_d   = '0;
        end
        REG_CMP_LO:   cmp_d = {cmp_q[63:32], wr_val};
        REG_CMP_HI:   cmp_d = {wr_val, cmp_q[31:0]};
        REG_STATUS:   if (wb.sel[0] && wb.wdat[0]) pending_d = 1'b0;
        default:      ;
      endcase
    end

    // A new match overrides a same-cycle clear so no event is lost.
    if (match) pending_d = 1'b1;
`ifdef WB_TIMER_ONESHOT_EN
    if (match && ctrl_q[3]) ctrl_d[0] = 1'b0;
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_q      <= '0;
      prescale_q  <= '0;
      psc_q       <= '0;
      count_q     <= '0;
      cmp_q       <= '1;
      pending_q   <= 1'b0;
      hi_shadow_q <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      psc_q       <= psc_d;
      count_q     <= count_d;
      cmp_q       <= cmp_d;
      pending_q   <= pending_d;
      hi_shadow_q <= hi_shadow_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  assign wb.ack  = ack_q;
  assign wb.rdat = dat_q;
  assign wb.err  = 1'b0;
  assign irq_o   = pending_q & ctrl_q[2];
endmodule

// File: tb/tb_wb_timer.sv
// Randomized self-checking bench for wb_timer against a cycle-level behavioural model.
module tb_wb_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  always #5 clk = ~clk;

  wb_timer_if bus ();

  wb_timer #(.PRESCALE_W(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus),
    .irq_o    (irq)
  );

`ifdef WB_TIMER_ONESHOT_EN
  localparam bit [3:0] CTRL_MASK = 4'hF;
  localparam bit       ONESHOT   = 1'b1;
`else
  localparam bit [3:0] CTRL_MASK = 4'h7;
  localparam bit       ONESHOT   = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model of the programmer-visible state.
  bit [3:0]  m_ctrl;
  bit [15:0] m_pre, m_psc;
  bit [63:0] m_cnt, m_cmp;
  bit        m_pend, m_ack;
  bit [31:0] m_sh, m_rdat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] lanes(input bit [31:0] old_v, input bit [31:0] new_v,
                                      input bit [3:0] sel);
    bit [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic bit [31:0] reg_read(input bit [2:0] r);
    case (r)
      3'd0: return {28'd0, m_ctrl};
      3'd1: return {16'd0, m_pre};
      3'd2: return m_cnt[31:0];
      3'd3: return m_sh;
      3'd4: return m_cmp[31:0];
      3'd5: return m_cmp[63:32];
      3'd6: return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock: predict from the inputs being driven, then compare outputs.
  task automatic cycle();
    bit [3:0]  n_ctrl;
    bit [15:0] n_pre, n_psc;
    bit [63:0] n_cnt, n_cmp;
    bit        n_pend, n_ack, acc, tick, hit, clr;
    bit [31:0] n_sh, n_rdat, nv, cv;
    bit [2:0]  r;
    n_ctrl = m_ctrl; n_pre = m_pre; n_psc = m_psc; n_cnt = m_cnt; n_cmp = m_cmp;
    n_pend = m_pend; n_sh = m_sh; n_rdat = m_rdat; n_ack = 1'b0;
    if (rst) begin
      n_ctrl = 0; n_pre = 0; n_psc = 0; n_cnt = 0; n_cmp = '1;
      n_pend = 0; n_sh = 0; n_rdat = 0;
    end else begin
      acc  = bus.cyc && bus.stb && !m_ack;
      r    = bus.adr[4:2];
      tick = m_ctrl[0] && (m_psc == m_pre);
      hit  = tick && (m_cnt == m_cmp);
      n_ack = acc;
      if (m_ctrl[0]) n_psc = tick ? 16'd0 : m_psc + 16'd1;
      if (tick) n_cnt = (hit && m_ctrl[1]) ? 64'd0 : m_cnt + 64'd1;
      if (hit) n_pend = 1'b1;
      if (acc && !bus.we) begin
        n_rdat = reg_read(r);
        if (r == 3'd2) n_sh = m_cnt[63:32];
      end
      if (acc && bus.we) begin
        case (r)
          3'd0: begin nv = lanes({28'd0, m_ctrl}, bus.wdat, bus.sel); n_ctrl = nv[3:0] & CTRL_MASK; end
          3'd1: begin
            nv = lanes({16'd0, m_pre}, bus.wdat, bus.sel);
            n_pre = nv[15:0];
            if (n_pre < m_psc) n_psc = 16'd0;
          end
          3'd2: begin n_cnt = {m_cnt[63:32], lanes(m_cnt[31:0], bus.wdat, bus.sel)}; n_psc = 0; end
          3'd3: begin n_cnt = {lanes(m_cnt[63:32], bus.wdat, bus.sel), m_cnt[31:0]}; n_psc = 0; end
          3'd4: n_cmp = {m_cmp[63:32], lanes(m_cmp[31:0], bus.wdat, bus.sel)};
          3'd5: n_cmp = {lanes(m_cmp[63:32], bus.wdat, bus.sel), m_cmp[31:0]};
          3'd6: begin
            cv = lanes(32'd0, bus.wdat, bus.sel);
            clr = cv[0];
            if (clr && !hit) n_pend = 1'b0;
          end
          default: ;
        endcase
      end
      if (ONESHOT && hit && m_ctrl[3]) n_ctrl[0] = 1'b0;
    end
    @(posedge clk);
    #1;
    m_ctrl = n_ctrl; m_pre = n_pre; m_psc = n_psc; m_cnt = n_cnt; m_cmp = n_cmp;
    m_pend = n_pend; m_sh = n_sh; m_rdat = n_rdat; m_ack = n_ack;
    check("ack", bus.ack, m_ack);
    check("irq", irq, m_pend & m_ctrl[2]);
    check("dat_o", bus.rdat, m_rdat);
    check("err", bus.err, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic xfer(input bit we, input bit [4:0] a, input bit [31:0] d,
                      input bit [3:0] s, output bit [31:0] rdata);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = a; bus.wdat = d; bus.sel = s;
    cycle();
    check("ack_latency", bus.ack, 1'b1);
    rdata = bus.rdat;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    cycle();
    $display("%s adr=%02h wdat=%08h sel=%h rdat=%08h irq=%0b", we ? "WR" : "RD",
             a, d, s, rdata, irq);
  endtask

  task automatic wr(input bit [4:0] a, input bit [31:0] d, input bit [3:0] s = 4'hF);
    bit [31:0] dummy;
    xfer(1'b1, a, d, s, dummy);
  endtask

  task automatic rd(input bit [4:0] a, output bit [31:0] d);
    xfer(1'b0, a, 32'd0, 4'hF, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // Reset lands on the same edge that would accept an access: no ack may follow.
  task automatic abort_reset();
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 5'h00; bus.wdat = 32'h7; bus.sel = 4'hF;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    cycle();
    $display("RST-ABORT adr=00 irq=%0b ack=%0b", irq, bus.ack);
  endtask

  initial begin
    bit [31:0] d, lo, hi, wd;
    bit [31:0] exp_reset [8];
    bit [4:0]  a;
    bit [3:0]  s;
    exp_reset = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.wdat = '0; bus.sel = '0;
    do_reset();
    do_reset();

    // Reset values at every offset.
    for (int i = 0; i < 8; i++) begin
      rd(5'(i * 4), d);
      check($sformatf("reset_reg%0d", i), d, exp_reset[i]);
    end

    // Prescale 3: count advances every 4th cycle.
    wr(5'h04, 32'd3);
    wr(5'h00, 32'h1);
    idle(39);
    rd(5'h08, d);
    check("prescale3_count", d, 32'd10);

    // Auto-reload period and W1C.
    do_reset();
    wr(5'h10, 32'd5);
    wr(5'h14, 32'd0);
    wr(5'h00, 32'h7);
    idle(15);
    wr(5'h18, 32'h1);
    idle(14);

    // Carry across the 32-bit boundary with coherent hi/lo read.
    do_reset();
    wr(5'h08, 32'hFFFF_FFFE);
    wr(5'h0C, 32'd0);
    wr(5'h00, 32'h1);
    rd(5'h08, lo);
    rd(5'h0C, hi);
    check("carry_pair_torn", (lo == 32'hFFFF_FFFF && hi == 32'd1), 1'b0);
    wr(5'h00, 32'h0);

    // Match on the same edge as a STATUS clear.
    do_reset();
    wr(5'h10, 32'd8);
    wr(5'h14, 32'd0);
    wr(5'h00, 32'h7);
    idle(12);
    wr(5'h18, 32'h1);
    for (int i = 0; i < 40 && m_cnt != m_cmp; i++) cycle();
    check("w1c_align", m_cnt == m_cmp, 1'b1);
    wr(5'h18, 32'h1);
    rd(5'h18, d);
    check("w1c_set_wins", d, 32'd1);
    check("w1c_irq_high", irq, 1'b1);

    // Byte-lane write and one-shot behaviour.
    do_reset();
    wr(5'h10, 32'hAABB_CCDD, 4'b0001);
    rd(5'h10, d);
    check("cmp_lo_bytelane", d, 32'hFFFF_FFDD);
    wr(5'h10, 32'd2);
    wr(5'h14, 32'd0);
    wr(5'h00, 32'hF);
    idle(10);
    rd(5'h00, d);
`ifdef WB_TIMER_ONESHOT_EN
    check("oneshot_ctrl", d, 32'hE);
    rd(5'h08, d);
    check("oneshot_count", d, 32'd0);
`else
    check("ctrl_bit3_ignored", d, 32'h7);
`endif

    // Randomized register traffic.
    do_reset();
    for (int t = 0; t < 200; t++) begin
      a = 5'($urandom_range(0, 7) * 4);
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case (a[4:2])
        3'd0: wd = $urandom_range(0, 15);
        3'd1: wd = $urandom_range(0, 3);
        3'd2: wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom_range(0, 20);
        3'd3: wd = $urandom_range(0, 1);
        3'd4: wd = $urandom_range(0, 24);
        3'd5: wd = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'd0;
        default: wd = $urandom;
      endcase
      if ($urandom_range(0, 39) == 0) abort_reset();
      else xfer($urandom_range(0, 1) == 1, a, wd, s, d);
      idle($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
